ama_riscv_wb_stage: RTL and testbench
=====================================

# ama_riscv_wb_stage

Writeback stage of the ama_riscv pipeline: a one-entry pipeline register fed by the MEM stage, driving the register-file write port (we/addr_d/data_d). It selects the writeback source (ALU, load, PC+4, CSR), aligns and sign-extends load data returned by data memory, and stalls MEM via a ready handshake while a load response is outstanding. It also exposes the in-flight writeback value to the forwarding logic.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM stage presents an instruction
- mem_ready  out  1  WB accepts; transfer when mem_valid && mem_ready at a rising edge
- mem_rd_we  in  1  instruction writes rd
- mem_rd_addr  in  5  destination register
- mem_wb_sel  in  2  0 ALU, 1 load, 2 PC+4, 3 CSR
- mem_alu  in  32  ALU result
- mem_pc  in  32  instruction PC
- mem_csr  in  32  CSR read data
- mem_ld_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- mem_ld_off  in  2  load address bits [1:0]
- dmem_rvalid  in  1  load response valid
- dmem_rdata  in  32  load response word (aligned word)
- rf_we  out  1  register-file write enable
- rf_addr_d  out  5  register-file write address
- rf_data_d  out  32  register-file write data
- fwd_valid  out  1  fwd_addr/fwd_data hold a committable value
- fwd_addr  out  5  forwarding destination
- fwd_data  out  32  forwarding value
- retired_cnt  out  CNT_W  retired instruction count

## Operation
- States: EMPTY, FULL, WAIT_LD. Reset -> EMPTY.
- mem_ready = (state != WAIT_LD).
- Accept in EMPTY or FULL (FULL entry retires the same edge it is replaced):
  - wb_sel 0/2/3: data = mem_alu / mem_pc+32'd4 (wrap mod 2^32) / mem_csr; -> FULL.
  - wb_sel 1: latch funct3, off, rd, rd_we; -> WAIT_LD.
- No accept: FULL -> EMPTY; EMPTY stays.
- WAIT_LD: on dmem_rvalid=1 store aligned data, -> FULL; else stay. dmem_rvalid ignored in EMPTY/FULL.
- Alignment: byte = dmem_rdata[8*off +: 8]; half = dmem_rdata[16*off[1] +: 16], off[0] ignored; LB/LH sign-extend, LBU/LHU zero-extend; funct3 011/110/111 treated as LW; LW ignores off.
- rf_we = (state==FULL) && rd_we && (rd != 0); rf_addr_d/rf_data_d = entry rd/data, driven from registers (no combinational path from mem_* inputs).
- fwd_valid = rf_we; fwd_addr/fwd_data = rf_addr_d/rf_data_d. In WAIT_LD fwd_valid=0; hazard logic stalls on mem_ready=0.
- Every FULL cycle retires exactly one instruction, including rd_we=0 or rd=0.

## Timing
- Reset values: state EMPTY, rf_we 0, rf_addr_d 0, rf_data_d 0, fwd_* 0, retired_cnt 0, mem_ready 1.
- Non-load: accepted at edge E -> rf_we high for cycle E..E+1; RF writes at E+1. Back-to-back accepts sustain 1 instr/cycle.
- Load: accepted at edge E; earliest response sampled at E+1; response at edge F -> rf_we high cycle F..F+1. mem_ready low from E to F.
- Reset mid WAIT_LD: load dropped, nothing written; a later dmem_rvalid is ignored.
- rst wins over any simultaneous accept or response.

## Configuration
- AMA_RISCV_WB_RETIRE_CNT_EN defined: retired_cnt increments by 1 every cycle state==FULL, wraps at 2^CNT_W, cleared by rst.
- Not defined: counter logic absent; retired_cnt tied to 0.

## Test plan
- ALU stream: 3 back-to-back accepts rd=1,2,3 alu=0x11,0x22,0x33 -> rf_we high 3 consecutive cycles, correct addr/data, mem_ready stays 1.
- Load alignment: LB off=3 rdata=0x80FF_0000 -> 0xFFFF_FF80; LHU off=2 rdata=0x8001_1234 -> 0x0000_8001; LH off=1 rdata=0x0000_F00F -> 0xFFFF_F00F.
- Load stall: LW accepted, dmem_rvalid after 4 cycles with 0xDEADBEEF -> mem_ready low 4 cycles, fwd_valid 0, then rf_we one cycle with 0xDEADBEEF.
- rd=x0 and rd_we=0: alu=0x5 -> rf_we never high; retired_cnt +1 each (macro defined).
- PC+4 wrap: wb_sel=2, pc=0xFFFF_FFFC -> rf_data_d 0x0000_0000.
- Reset during WAIT_LD, then dmem_rvalid=1 -> no write, state EMPTY, retired_cnt 0.

Source files
------------

// File: rtl/ama_riscv_wb_stage.sv
// Writeback stage: one-entry register between MEM and the register-file write port.
// Optional retired-instruction counter enabled by defining AMA_RISCV_WB_RETIRE_CNT_EN.
module ama_riscv_wb_stage #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic             mem_rd_we,
   input  logic [4:0]       mem_rd_addr,
   input  logic [1:0]       mem_wb_sel,
   input  logic [31:0]      mem_alu,
   input  logic [31:0]      mem_pc,
   input  logic [31:0]      mem_csr,
   input  logic [2:0]       mem_ld_funct3,
   input  logic [1:0]       mem_ld_off,
   input  logic             dmem_rvalid,
   input  logic [31:0]      dmem_rdata,
   output logic             rf_we,
   output logic [4:0]       rf_addr_d,
   output logic [31:0]      rf_data_d,
   output logic             fwd_valid,
   output logic [4:0]       fwd_addr,
   output logic [31:0]      fwd_data,
   output logic [CNT_W-1:0] retired_cnt
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FULL    = 2'd1,
      WAIT_LD = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic        ld_done;
   logic [4:0]  rd_q;
   logic        rd_we_q;
   logic [31:0] data_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [31:0] wb_src;
   logic [31:0] ld_data;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign mem_ready = (state != WAIT_LD);
   assign accept    = mem_valid && mem_ready;
   assign ld_done   = (state == WAIT_LD) && dmem_rvalid;

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY, FULL: begin
            if (accept) state_nxt = (mem_wb_sel == 2'd1) ? WAIT_LD : FULL;
            else        state_nxt = EMPTY;
         end
         WAIT_LD: begin
            if (dmem_rvalid) state_nxt = FULL;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      case (mem_wb_sel)
         2'd2:    wb_src = mem_pc + 32'd4;
         2'd3:    wb_src = mem_csr;
         default: wb_src = mem_alu;
      endcase
   end

   // Loads use the funct3/offset captured at accept, not the live MEM inputs.
   always_comb begin
      case (off_q)
         2'd0: ld_byte = dmem_rdata[7:0];
         2'd1: ld_byte = dmem_rdata[15:8];
         2'd2: ld_byte = dmem_rdata[23:16];
         2'd3: ld_byte = dmem_rdata[31:24];
         default: ld_byte = dmem_rdata[7:0];
      endcase
      ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q     <= '0;
         rd_we_q  <= 1'b0;
         data_q   <= '0;
         funct3_q <= '0;
         off_q    <= '0;
      end else if (ld_done) begin
         data_q <= ld_data;
      end else if (accept) begin
         rd_q    <= mem_rd_addr;
         rd_we_q <= mem_rd_we;
         if (mem_wb_sel == 2'd1) begin
            funct3_q <= mem_ld_funct3;
            off_q    <= mem_ld_off;
         end else begin
            data_q <= wb_src;
         end
      end
   end

   assign rf_we     = (state == FULL) && rd_we_q && (rd_q != 5'd0);
   assign rf_addr_d = rd_q;
   assign rf_data_d = data_q;
   assign fwd_valid = rf_we;
   assign fwd_addr  = rd_q;
   assign fwd_data  = data_q;

`ifdef AMA_RISCV_WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)                 cnt_q <= '0;
      else if (state == FULL) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign retired_cnt = cnt_q;
`else
   assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_ama_riscv_wb_stage.sv
// Self-checking bench for ama_riscv_wb_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_ama_riscv_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_rd_we;
   logic [4:0]  mem_rd_addr;
   logic [1:0]  mem_wb_sel;
   logic [31:0] mem_alu, mem_pc, mem_csr;
   logic [2:0]  mem_ld_funct3;
   logic [1:0]  mem_ld_off;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        rf_we;
   logic [4:0]  rf_addr_d;
   logic [31:0] rf_data_d;
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic [31:0] retired_cnt;

   int checks   = 0;
   int failures = 0;

   ama_riscv_wb_stage #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr), .mem_wb_sel(mem_wb_sel),
      .mem_alu(mem_alu), .mem_pc(mem_pc), .mem_csr(mem_csr),
      .mem_ld_funct3(mem_ld_funct3), .mem_ld_off(mem_ld_off),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .rf_we(rf_we), .rf_addr_d(rf_addr_d), .rf_data_d(rf_data_d),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: what the stage is holding, described as a transaction.
   bit          has_result;
   bit          awaiting_load;
   logic [4:0]  m_rd;
   bit          m_we;
   logic [31:0] m_data;
   logic [2:0]  m_f3;
   logic [1:0]  m_off;
   logic [31:0] m_cnt;

   function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> (32'(off) * 8)) & 32'h0000_00FF;
      h = (word >> (32'(off[1]) * 16)) & 32'h0000_FFFF;
      case (f3)
         3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return word;
      endcase
   endfunction

   function automatic bit cnt_enabled();
`ifdef AMA_RISCV_WB_RETIRE_CNT_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_edge();
      if (rst) begin
         has_result = 0; awaiting_load = 0;
         m_rd = 0; m_we = 0; m_data = 0; m_f3 = 0; m_off = 0; m_cnt = 0;
      end else begin
         if (has_result && cnt_enabled()) m_cnt = m_cnt + 1;
         if (awaiting_load) begin
            if (dmem_rvalid) begin
               m_data = load_value(m_f3, m_off, dmem_rdata);
               awaiting_load = 0;
               has_result = 1;
            end
         end else if (mem_valid) begin
            m_rd = mem_rd_addr;
            m_we = mem_rd_we;
            if (mem_wb_sel == 2'd1) begin
               m_f3 = mem_ld_funct3; m_off = mem_ld_off;
               awaiting_load = 1; has_result = 0;
            end else begin
               m_data = (mem_wb_sel == 2'd0) ? mem_alu :
                        (mem_wb_sel == 2'd2) ? mem_pc + 32'd4 : mem_csr;
               has_result = 1;
            end
         end else begin
            has_result = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      bit exp_we;
      model_edge();
      @(posedge clk);
      #1;
      exp_we = has_result && m_we && (m_rd != 5'd0);
      check("mem_ready",   32'(mem_ready), 32'(!awaiting_load));
      check("rf_we",       32'(rf_we), 32'(exp_we));
      check("fwd_valid",   32'(fwd_valid), 32'(exp_we));
      check("retired_cnt", retired_cnt, m_cnt);
      if (exp_we) begin
         check("rf_addr_d", 32'(rf_addr_d), 32'(m_rd));
         check("rf_data_d", rf_data_d, m_data);
         check("fwd_addr",  32'(fwd_addr), 32'(m_rd));
         check("fwd_data",  fwd_data, m_data);
      end
   endtask

   task automatic idle();
      mem_valid = 0; dmem_rvalid = 0;
   endtask

   task automatic issue(input bit we, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic [31:0] csr, input logic [2:0] f3, input logic [1:0] off);
      mem_valid = 1; mem_rd_we = we; mem_rd_addr = rd; mem_wb_sel = sel;
      mem_alu = alu; mem_pc = pc; mem_csr = csr; mem_ld_funct3 = f3; mem_ld_off = off;
   endtask

   task automatic load_test(input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] word, input logic [31:0] lit, input string tag);
      issue(1, 5'd7, 2'd1, 32'h0, 32'h0, 32'h0, f3, off); cycle();
      idle(); dmem_rvalid = 1; dmem_rdata = word; cycle();
      check(tag, rf_data_d, lit);
      idle(); cycle();
   endtask

   initial begin
      rst = 1; idle();
      mem_rd_we = 0; mem_rd_addr = 0; mem_wb_sel = 0; mem_alu = 0; mem_pc = 0;
      mem_csr = 0; mem_ld_funct3 = 0; mem_ld_off = 0; dmem_rdata = 0;
      cycle(); cycle();
      check("reset_rf_addr", 32'(rf_addr_d), 32'd0);
      check("reset_rf_data", rf_data_d, 32'd0);
      rst = 0; cycle();

      // ALU stream, back-to-back
      issue(1, 5'd1, 2'd0, 32'h11, 32'h0, 32'h0, 3'b0, 2'd0); cycle();
      check("alu1_lit", rf_data_d, 32'h11);
      issue(1, 5'd2, 2'd0, 32'h22, 32'h0, 32'h0, 3'b0, 2'd0); cycle();
      issue(1, 5'd3, 2'd0, 32'h33, 32'h0, 32'h0, 3'b0, 2'd0); cycle();
      check("alu3_lit", rf_data_d, 32'h33);
      idle(); cycle();

      // Load alignment
      load_test(3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80, "lb_off3");
      load_test(3'b101, 2'd2, 32'h8001_1234, 32'h0000_8001, "lhu_off2");
      load_test(3'b001, 2'd1, 32'h0000_F00F, 32'hFFFF_F00F, "lh_off1");

      // Load stall: response four cycles after accept
      issue(1, 5'd9, 2'd1, 32'h0, 32'h0, 32'h0, 3'b010, 2'd0); cycle();
      idle();
      for (int i = 0; i < 3; i++) cycle();
      dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF; cycle();
      check("lw_lit", rf_data_d, 32'hDEAD_BEEF);
      idle(); cycle();

      // rd=x0 and rd_we=0 still retire
      issue(1, 5'd0, 2'd0, 32'h5, 32'h0, 32'h0, 3'b0, 2'd0); cycle();
      issue(0, 5'd4, 2'd0, 32'h5, 32'h0, 32'h0, 3'b0, 2'd0); cycle();
      idle(); cycle();

      // PC+4 wrap and CSR source
      issue(1, 5'd5, 2'd2, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'b0, 2'd0); cycle();
      check("pc4_wrap_lit", rf_data_d, 32'h0);
      issue(1, 5'd6, 2'd3, 32'h0, 32'h0, 32'hCAFE_0001, 3'b0, 2'd0); cycle();
      idle(); cycle();

      // Reset while a load is outstanding, then a stale response
      issue(1, 5'd8, 2'd1, 32'h0, 32'h0, 32'h0, 3'b010, 2'd0); cycle();
      idle(); cycle();
      rst = 1; dmem_rvalid = 1; dmem_rdata = 32'h1234_5678; cycle();
      rst = 0; cycle();
      check("rst_ld_cnt", retired_cnt, 32'd0);
      idle(); cycle();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         rst           = ($urandom_range(0, 59) == 0);
         mem_valid     = $urandom_range(0, 3) != 0;
         mem_rd_we     = $urandom_range(0, 3) != 0;
         mem_rd_addr   = 5'($urandom);
         mem_wb_sel    = 2'($urandom);
         mem_alu       = $urandom;
         mem_pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         mem_csr       = $urandom;
         mem_ld_funct3 = 3'($urandom);
         mem_ld_off    = 2'($urandom);
         dmem_rvalid   = $urandom_range(0, 1) != 0;
         dmem_rdata    = $urandom;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
